// File: rtl/hex_entry_writer_pkg.sv
// Shared definitions for the push-button hex entry path: write FSM states,
// button indices into the conditioned-button vector, default write base and
// the nibble-increment helper used by the edit datapath.
package hex_entry_writer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wr_state_t;

    localparam int unsigned BTN_LEFT  = 0;
    localparam int unsigned BTN_RIGHT = 1;
    localparam int unsigned BTN_UP    = 2;
    localparam int unsigned BTN_ENTER = 3;
    localparam int unsigned BTN_COUNT = 4;

    localparam logic [31:0] WR_BASE_DEFAULT = 32'h0000_0080;
    localparam logic [2:0]  CURSOR_MAX      = 3'd7;

    // Increment one nibble modulo 16; neighbouring nibbles never see a carry.
    function automatic logic [31:0] nibble_inc(input logic [31:0] value,
                                               input logic [2:0]  idx);
        logic [31:0] result;
        result = value;
        for (int unsigned i = 0; i < 8; i++) begin
            if (3'(i) == idx) begin
                result[4*i +: 4] = value[4*i +: 4] + 4'd1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/hex_entry_writer_btn_conditioner.sv
// Raw push-button conditioning: two-flop synchronizer, stability-counter
// debounce and a single-cycle pulse on each debounced press (0->1 edge).
module btn_conditioner #(
    parameter int unsigned DB_CYCLES = 500000
) (
    input  logic CLK_RAW,
    input  logic RESET_N,
    input  logic button_raw,
    output logic press
);

    localparam int unsigned       CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(DB_CYCLES);

    logic             sync_a;
    logic             sync_b;
    logic             sync_prev;
    logic             level;
    logic [CNT_W-1:0] stable_cnt;

    // Synchronize, count clocks of unchanged synced level, adopt it once stable, pulse on rise.
    always_ff @(posedge CLK_RAW or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_a     <= 1'b0;
            sync_b     <= 1'b0;
            sync_prev  <= 1'b0;
            level      <= 1'b0;
            stable_cnt <= '0;
            press      <= 1'b0;
        end else begin
            sync_a    <= button_raw;
            sync_b    <= sync_a;
            sync_prev <= sync_b;
            press     <= 1'b0;
            if (sync_b != sync_prev) begin
                stable_cnt <= '0;
            end else begin
                if (stable_cnt != CNT_SAT) begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
                if (stable_cnt == CNT_LAST) begin
                    level <= sync_b;
                    press <= sync_b & ~level;
                end
            end
        end
    end

endmodule

// File: rtl/hex_entry_writer.sv
// Board-side hex entry: four debounced buttons edit a 32-bit value nibble by
// nibble, ENTER commits it as a valid/ready word write to the next slot.
module hex_entry_writer
    import hex_entry_writer_pkg::*;
#(
    parameter  int unsigned DB_CYCLES = 500000,
    parameter  logic [31:0] WR_BASE   = WR_BASE_DEFAULT,
    parameter  int unsigned WR_DEPTH  = 8,
    localparam int unsigned SLOT_W    = $clog2(WR_DEPTH)
) (
    input  logic              CLK_RAW,
    input  logic              RESET_N,
    input  logic              BUTTON_LEFT,
    input  logic              BUTTON_RIGHT,
    input  logic              BUTTON_UP,
    input  logic              BUTTON_ENTER,
    output logic [31:0]       entry_value,
    output logic [2:0]        cursor,
    output logic              wr_valid,
    output logic [31:0]       wr_addr,
    output logic [31:0]       wr_data,
    input  logic              wr_ready,
    output logic              wr_done,
    output logic [SLOT_W-1:0] slot
);

    logic [BTN_COUNT-1:0] button_raw;
    logic [BTN_COUNT-1:0] press;
    logic [31:0]          slot_addr;
    wr_state_t            state;

    assign button_raw[BTN_LEFT]  = BUTTON_LEFT;
    assign button_raw[BTN_RIGHT] = BUTTON_RIGHT;
    assign button_raw[BTN_UP]    = BUTTON_UP;
    assign button_raw[BTN_ENTER] = BUTTON_ENTER;

    for (genvar g = 0; g < BTN_COUNT; g++) begin : g_btn
        btn_conditioner #(
            .DB_CYCLES (DB_CYCLES)
        ) u_btn (
            .CLK_RAW    (CLK_RAW),
            .RESET_N    (RESET_N),
            .button_raw (button_raw[g]),
            .press      (press[g])
        );
    end

    // Word address of the current slot; 32-bit wraparound, low two bits always zero.
    assign slot_addr = WR_BASE + {{(32 - SLOT_W - 2){1'b0}}, slot, 2'b00};

    // Edit datapath and write FSM: one prioritized action per cycle in IDLE, handshake in WRITE.
    always_ff @(posedge CLK_RAW or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= IDLE;
            entry_value <= '0;
            cursor      <= '0;
            wr_valid    <= 1'b0;
            wr_addr     <= WR_BASE;
            wr_data     <= '0;
            wr_done     <= 1'b0;
            slot        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wr_done <= 1'b0;
                    if (press[BTN_ENTER]) begin
                        wr_data  <= entry_value;
                        wr_addr  <= slot_addr;
                        wr_valid <= 1'b1;
                        state    <= WRITE;
                    end else if (press[BTN_UP]) begin
                        entry_value <= nibble_inc(entry_value, cursor);
                    end else if (press[BTN_LEFT]) begin
                        if (cursor != CURSOR_MAX) begin
                            cursor <= cursor + 3'd1;
                        end
                    end else if (press[BTN_RIGHT]) begin
                        if (cursor != 3'd0) begin
                            cursor <= cursor - 3'd1;
                        end
                    end
                end
                WRITE: begin
                    if (wr_valid && wr_ready) begin
                        wr_valid <= 1'b0;
                        wr_done  <= 1'b1;
                        slot     <= slot + 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_entry_writer.sv
module tb_hex_entry_writer;

    localparam int unsigned DB    = 4;
    localparam int unsigned HOLD  = 14;
    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h0000_0080;
    localparam int unsigned OP_LEFT = 0, OP_RIGHT = 1, OP_UP = 2, OP_ENTER = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  btn = '0;
    logic        wr_ready = 1'b0;
    logic [31:0] entry_value;
    logic [2:0]  cursor;
    logic        wr_valid;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_done;
    logic [2:0]  slot;

    always #5 clk = ~clk;

    hex_entry_writer #(
        .DB_CYCLES (DB),
        .WR_BASE   (BASE),
        .WR_DEPTH  (DEPTH)
    ) dut (
        .CLK_RAW      (clk),
        .RESET_N      (rst_n),
        .BUTTON_LEFT  (btn[0]),
        .BUTTON_RIGHT (btn[1]),
        .BUTTON_UP    (btn[2]),
        .BUTTON_ENTER (btn[3]),
        .entry_value  (entry_value),
        .cursor       (cursor),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .wr_done      (wr_done),
        .slot         (slot)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    typedef struct {
        int unsigned op;
        logic [31:0] exp_val;
        logic [2:0]  exp_cur;
    } vec_t;

    xfer_t       got_q[$];
    xfer_t       exp_q[$];
    int          done_cnt = 0;
    int          nvec = 0;
    int          nerr = 0;

    logic [31:0] m_val;
    int unsigned m_cur;
    int unsigned m_slot;
    int          m_done;

    // Transfers and done pulses observed on the write port
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_valid && wr_ready) got_q.push_back('{wr_addr, wr_data});
            if (wr_done) done_cnt++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic press(input logic [3:0] mask);
        btn = mask;
        repeat (HOLD) tick();
        btn = '0;
        repeat (HOLD) tick();
    endtask

    // Spec-level model of one accepted action
    task automatic model_op(input int unsigned op);
        logic [31:0] nib;
        case (op)
            OP_LEFT:  if (m_cur < 7) m_cur++;
            OP_RIGHT: if (m_cur > 0) m_cur--;
            OP_UP: begin
                nib   = ((m_val >> (4 * m_cur)) + 32'd1) & 32'hF;
                m_val = (m_val & ~(32'hF << (4 * m_cur))) | (nib << (4 * m_cur));
            end
            default: begin
                exp_q.push_back('{BASE + 32'(4 * m_slot), m_val});
                m_slot = (m_slot + 1) % DEPTH;
                m_done++;
            end
        endcase
    endtask

    task automatic do_op(input int unsigned op);
        press(4'b0001 << op);
        model_op(op);
    endtask

    task automatic check_state(input string name);
        chk({name, "_value"},  entry_value, m_val);
        chk({name, "_cursor"}, 32'(cursor), 32'(m_cur));
        chk({name, "_slot"},   32'(slot),   32'(m_slot));
    endtask

    task automatic check_writes(input string name);
        xfer_t g, e;
        chk({name, "_xfer_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        chk({name, "_done_count"}, 32'(done_cnt), 32'(m_done));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk({name, "_addr"}, g.addr, e.addr);
            chk({name, "_data"}, g.data, e.data);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic goto_cursor(input int unsigned c);
        while (m_cur < c) do_op(OP_LEFT);
        while (m_cur > c) do_op(OP_RIGHT);
    endtask

    task automatic set_value(input logic [31:0] v);
        logic [31:0] cur_n, tgt_n;
        for (int n = 7; n >= 0; n--) begin
            goto_cursor(n);
            cur_n = (m_val >> (4 * n)) & 32'hF;
            tgt_n = (v >> (4 * n)) & 32'hF;
            repeat ((tgt_n - cur_n) & 32'hF) do_op(OP_UP);
        end
    endtask

    task automatic wait_valid(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (wr_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({name, "_valid_timeout"}, 32'(wr_valid), 32'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_value"}, entry_value, 32'h0);
        chk({name, "_cursor"}, 32'(cursor), 32'h0);
        chk({name, "_valid"}, 32'(wr_valid), 32'h0);
        chk({name, "_addr"}, wr_addr, BASE);
        chk({name, "_data"}, wr_data, 32'h0);
        chk({name, "_done"}, 32'(wr_done), 32'h0);
        chk({name, "_slot"}, 32'(slot), 32'h0);
    endtask

    initial begin
        vec_t tbl[$];
        bit   ok;
        int   done_before;

        // Table: UP x16 on nibble 0, LEFT x9, UP, RIGHT x10
        for (int i = 0; i < 16; i++) tbl.push_back('{OP_UP, 32'((i + 1) % 16), 3'd0});
        for (int i = 0; i < 9; i++)  tbl.push_back('{OP_LEFT, 32'h0, (i < 7) ? 3'(i + 1) : 3'd7});
        tbl.push_back('{OP_UP, 32'h1000_0000, 3'd7});
        for (int i = 0; i < 10; i++) tbl.push_back('{OP_RIGHT, 32'h1000_0000, (i < 7) ? 3'(6 - i) : 3'd0});

        m_val = '0; m_cur = 0; m_slot = 0; m_done = 0;

        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (4) tick();

        foreach (tbl[i]) begin
            do_op(tbl[i].op);
            chk($sformatf("tbl%0d_value", i), entry_value, tbl[i].exp_val);
            chk($sformatf("tbl%0d_cursor", i), 32'(cursor), 32'(tbl[i].exp_cur));
        end

        // Short pulse (DB-2 clocks) and a bounce train: no action
        btn[OP_UP] = 1'b1;
        repeat (DB - 2) tick();
        btn = '0;
        repeat (HOLD) tick();
        for (int i = 0; i < 12; i++) begin
            btn[OP_UP] = ~btn[OP_UP];
            tick();
        end
        btn = '0;
        repeat (HOLD) tick();
        check_state("glitch");

        // Long hold: exactly one increment
        btn[OP_UP] = 1'b1;
        repeat (80) tick();
        btn = '0;
        repeat (HOLD) tick();
        model_op(OP_UP);
        check_state("held");

        // DEADBEEF with memory stalled five cycles
        set_value(32'hDEAD_BEEF);
        check_state("deadbeef");
        wr_ready = 1'b0;
        btn[OP_ENTER] = 1'b1;
        wait_valid("stall", ok);
        if (ok) begin
            for (int i = 0; i < 5; i++) begin
                chk("stall_valid", 32'(wr_valid), 32'd1);
                chk("stall_addr", wr_addr, BASE);
                chk("stall_data", wr_data, 32'hDEAD_BEEF);
                chk("stall_done", 32'(wr_done), 32'd0);
                tick();
            end
            wr_ready = 1'b1;
            tick();
            chk("xfer_valid_low", 32'(wr_valid), 32'd0);
            chk("xfer_done", 32'(wr_done), 32'd1);
            chk("xfer_slot", 32'(slot), 32'd1);
            tick();
            chk("done_one_cycle", 32'(wr_done), 32'd0);
        end
        btn = '0;
        repeat (HOLD) tick();
        model_op(OP_ENTER);
        check_writes("stall");
        check_state("after_stall");

        // Nine commits with ready tied high: slots run through and wrap
        for (int i = 0; i < 9; i++) do_op(OP_ENTER);
        check_writes("wrap");
        check_state("wrap");

        // ENTER and UP together: ENTER wins, UP dropped
        press(4'b1100);
        model_op(OP_ENTER);
        check_writes("enter_up");
        check_state("enter_up");

        // Reset during a stalled write: everything returns to reset values, no transfer
        wr_ready = 1'b0;
        btn[OP_ENTER] = 1'b1;
        wait_valid("abort", ok);
        tick();
        done_before = done_cnt;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        btn = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        m_val = '0; m_cur = 0; m_slot = 0;
        wr_ready = 1'b1;
        repeat (HOLD) tick();
        chk("abort_no_xfer", 32'(got_q.size()), 32'd0);
        chk("abort_no_done", 32'(done_cnt), 32'(done_before));
        check_state("abort_idle");

        // Random actions against the model
        for (int i = 0; i < 60; i++) begin
            do_op($urandom_range(0, 3));
            check_state($sformatf("rand%0d", i));
        end
        check_writes("rand");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
